// File: rtl/i3c_engine_pkg.sv
// Shared I3C engine definitions: datapath mode codes, regfile addresses,
// arbiter state encoding and a small index helper.
package i3c_engine_pkg;

  // TX serializer modes
  localparam logic [2:0] TX_SERIALIZE   = 3'b001;
  localparam logic [2:0] TX_PARITY      = 3'b011;

  // RX deserializer modes
  localparam logic [2:0] RX_ACK         = 3'b000;
  localparam logic [2:0] RX_ARBITRATION = 3'b010;

  // Regfile address constants
  localparam logic [6:0] REGF_BCAST_W   = 7'd46;
  localparam logic [6:0] REGF_DDR_CODE  = 7'd50;

  // Arbiter states; ACTIVE is the only state that drives the datapath
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_LAUNCH  = 2'b01,
    ST_ACTIVE  = 2'b11,
    ST_RELEASE = 2'b10
  } arb_state_e;

  // Next index after idx, wrapping to 0 at n
  function automatic logic [2:0] wrap_inc(input logic [2:0] idx, input int unsigned n);
    logic [2:0] res;
    if ({29'd0, idx} >= (n - 32'd1)) begin
      res = 3'd0;
    end else begin
      res = idx + 3'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/ccc_engine_arbiter_rr_pick.sv
// Rotate-priority find-first: returns the first set request at or above
// ptr, wrapping around, so the most recently served engine goes last.
module ccc_rr_pick
  import i3c_engine_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [2:0]       ptr,
  output logic             valid,
  output logic [2:0]       idx
);

  // Scan from the farthest offset down so the nearest offset from ptr wins
  always_comb begin
    valid = 1'b0;
    idx   = 3'd0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      int  sum;
      int  j;
      logic hit;
      sum   = int'(ptr) + i;
      j     = (sum >= N_REQ) ? (sum - N_REQ) : sum;
      hit   = req[j];
      idx   = hit ? 3'(j) : idx;
      valid = valid | hit;
    end
  end

endmodule

// File: rtl/ccc_engine_arbiter.sv
// Round-robin owner of the shared I3C engine datapath. Launches one CCC
// sub-engine at a time, muxes its control bundle onto the datapath while
// ACTIVE, and releases on done or timeout.
module ccc_engine_arbiter
  import i3c_engine_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int ADDR_W  = 10,
  parameter int TMO_W   = 16,
  parameter int TMO_CYC = 40000
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [N_REQ-1:0]        i_req,
  output logic [N_REQ-1:0]        o_req_done,
  output logic [N_REQ-1:0]        o_eng_en,
  output logic [N_REQ-1:0]        o_eng_abort,
  input  logic [N_REQ-1:0]        i_eng_done,
  input  logic [N_REQ-1:0]        i_tx_en,
  input  logic [3*N_REQ-1:0]      i_tx_mode,
  input  logic [N_REQ-1:0]        i_rx_en,
  input  logic [3*N_REQ-1:0]      i_rx_mode,
  input  logic [N_REQ-1:0]        i_regf_rd_en,
  input  logic [ADDR_W*N_REQ-1:0] i_regf_addr,
  input  logic [N_REQ-1:0]        i_bit_cnt_en,
  input  logic [N_REQ-1:0]        i_pp_od,
  output logic                    o_tx_en,
  output logic [2:0]              o_tx_mode,
  output logic                    o_rx_en,
  output logic [2:0]              o_rx_mode,
  output logic                    o_regf_rd_en,
  output logic [ADDR_W-1:0]       o_regf_addr,
  output logic                    o_bit_cnt_en,
  output logic                    o_pp_od,
  output logic                    o_busy,
  output logic [2:0]              o_grant_id,
  output logic                    o_timeout
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
  localparam logic [N_REQ-1:0] OH_ONE   = N_REQ'(1);

  arb_state_e         state, next_state;
  logic [2:0]         ptr, next_ptr;
  logic [2:0]         grant_id, next_grant;
  logic [TMO_W-1:0]   tmo_cnt, next_tmo;
  logic [N_REQ-1:0]   eng_en, next_eng_en;
  logic [N_REQ-1:0]   eng_abort, next_abort;
  logic [N_REQ-1:0]   req_done, next_done;
  logic               timeout, next_timeout;

  logic               pick_valid;
  logic [2:0]         pick_idx;
  logic [N_REQ-1:0]   pick_oh;
  logic [N_REQ-1:0]   grant_oh;
  logic [N_REQ-1:0]   sel;
  logic               done_hit;

  ccc_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req   (i_req),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // One-hot forms of the candidate and the current grant
  always_comb begin
    pick_oh  = OH_ONE << pick_idx;
    grant_oh = OH_ONE << grant_id;
    done_hit = |(i_eng_done & grant_oh);
  end

  // State, counters and registered pulses; reset wins over any in-flight event
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      ptr       <= 3'd0;
      grant_id  <= 3'd0;
      tmo_cnt   <= {TMO_W{1'b0}};
      eng_en    <= {N_REQ{1'b0}};
      eng_abort <= {N_REQ{1'b0}};
      req_done  <= {N_REQ{1'b0}};
      timeout   <= 1'b0;
    end else begin
      state     <= next_state;
      ptr       <= next_ptr;
      grant_id  <= next_grant;
      tmo_cnt   <= next_tmo;
      eng_en    <= next_eng_en;
      eng_abort <= next_abort;
      req_done  <= next_done;
      timeout   <= next_timeout;
    end
  end

  // Next-state logic; pulses are computed one state early so they register into the target state
  always_comb begin
    next_state   = state;
    next_ptr     = ptr;
    next_grant   = grant_id;
    next_tmo     = tmo_cnt;
    next_eng_en  = {N_REQ{1'b0}};
    next_abort   = {N_REQ{1'b0}};
    next_done    = {N_REQ{1'b0}};
    next_timeout = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          next_grant  = pick_idx;
          next_eng_en = pick_oh;
          next_state  = ST_LAUNCH;
        end else begin
          next_state  = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        next_tmo   = {TMO_W{1'b0}};
        next_state = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        next_tmo = tmo_cnt + TMO_ONE;
        if (done_hit) begin
          next_done  = grant_oh;
          next_state = ST_RELEASE;
        end else if (tmo_cnt == TMO_LAST) begin
          next_done    = grant_oh;
          next_abort   = grant_oh;
          next_timeout = 1'b1;
          next_state   = ST_RELEASE;
        end else begin
          next_state = ST_ACTIVE;
        end
      end
      ST_RELEASE: begin
        next_ptr   = wrap_inc(grant_id, 32'(N_REQ));
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Datapath select: only the granted engine, and only while ACTIVE
  always_comb begin
    if (state == ST_ACTIVE) begin
      sel = grant_oh;
    end else begin
      sel = {N_REQ{1'b0}};
    end
  end

  // AND-OR bundle mux; zero whenever nothing is selected
  always_comb begin
    o_tx_en      = 1'b0;
    o_tx_mode    = 3'b000;
    o_rx_en      = 1'b0;
    o_rx_mode    = 3'b000;
    o_regf_rd_en = 1'b0;
    o_regf_addr  = {ADDR_W{1'b0}};
    o_bit_cnt_en = 1'b0;
    o_pp_od      = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      o_tx_en      = o_tx_en      | (i_tx_en[k]      & sel[k]);
      o_tx_mode    = o_tx_mode    | (i_tx_mode[k*3 +: 3] & {3{sel[k]}});
      o_rx_en      = o_rx_en      | (i_rx_en[k]      & sel[k]);
      o_rx_mode    = o_rx_mode    | (i_rx_mode[k*3 +: 3] & {3{sel[k]}});
      o_regf_rd_en = o_regf_rd_en | (i_regf_rd_en[k] & sel[k]);
      o_regf_addr  = o_regf_addr  | (i_regf_addr[k*ADDR_W +: ADDR_W] & {ADDR_W{sel[k]}});
      o_bit_cnt_en = o_bit_cnt_en | (i_bit_cnt_en[k] & sel[k]);
      o_pp_od      = o_pp_od      | (i_pp_od[k]      & sel[k]);
    end
  end

  assign o_eng_en    = eng_en;
  assign o_eng_abort = eng_abort;
  assign o_req_done  = req_done;
  assign o_timeout   = timeout;
  assign o_grant_id  = grant_id;
  assign o_busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_ccc_engine_arbiter.sv
// Directed bench for ccc_engine_arbiter: reset, round-robin order, bundle
// mux, timeout, foreign done and mid-transfer reset.
module tb_ccc_engine_arbiter;

  localparam int TMO = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req, eng_done, tx_en, rx_en, regf_rd_en, bit_cnt_en, pp_od;
  logic [11:0] tx_mode, rx_mode;
  logic [39:0] regf_addr;
  logic [3:0]  req_done, eng_en, eng_abort;
  logic        o_tx_en, o_rx_en, o_regf_rd_en, o_bit_cnt_en, o_pp_od;
  logic [2:0]  o_tx_mode, o_rx_mode;
  logic [9:0]  o_regf_addr;
  logic        busy, timeout;
  logic [2:0]  grant_id;

  int checks = 0;
  int errors = 0;

  ccc_engine_arbiter #(.N_REQ(4), .ADDR_W(10), .TMO_W(16), .TMO_CYC(TMO)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .o_req_done(req_done),
    .o_eng_en(eng_en), .o_eng_abort(eng_abort), .i_eng_done(eng_done),
    .i_tx_en(tx_en), .i_tx_mode(tx_mode), .i_rx_en(rx_en), .i_rx_mode(rx_mode),
    .i_regf_rd_en(regf_rd_en), .i_regf_addr(regf_addr), .i_bit_cnt_en(bit_cnt_en),
    .i_pp_od(pp_od), .o_tx_en(o_tx_en), .o_tx_mode(o_tx_mode), .o_rx_en(o_rx_en),
    .o_rx_mode(o_rx_mode), .o_regf_rd_en(o_regf_rd_en), .o_regf_addr(o_regf_addr),
    .o_bit_cnt_en(o_bit_cnt_en), .o_pp_od(o_pp_od), .o_busy(busy),
    .o_grant_id(grant_id), .o_timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req = 4'b0000; eng_done = 4'b0000; tx_en = 4'b0000; rx_en = 4'b0000;
    regf_rd_en = 4'b0000; bit_cnt_en = 4'b0000; pp_od = 4'b0000;
    tx_mode = 12'h000; rx_mode = 12'h000; regf_addr = 40'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    req = 4'b0100;
    rst = 1'b1;
    tick(); tick(); tick();
    checks++; if (eng_en !== 4'b0000) begin errors++; $display("FAIL rst_eng_en got %b want 0000", eng_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (req_done !== 4'b0000 || eng_abort !== 4'b0000 || timeout !== 1'b0) begin
      errors++; $display("FAIL rst_pulses got done=%b abort=%b tmo=%b want 0", req_done, eng_abort, timeout); end
    checks++; if (grant_id !== 3'd0) begin errors++; $display("FAIL rst_grant got %0d want 0", grant_id); end
    checks++; if ({o_tx_en, o_tx_mode, o_rx_en, o_rx_mode, o_regf_rd_en, o_regf_addr, o_bit_cnt_en, o_pp_od} !== 22'd0) begin
      errors++; $display("FAIL rst_bundle got nonzero bundle want 0"); end
    rst = 1'b0;
    tick();
    checks++; if (eng_en !== 4'b0100) begin errors++; $display("FAIL rst_launch got %b want 0100", eng_en); end
    checks++; if (grant_id !== 3'd2) begin errors++; $display("FAIL rst_launch_id got %0d want 2", grant_id); end
    tick();
    checks++; if (eng_en !== 4'b0000 || busy !== 1'b1) begin
      errors++; $display("FAIL launch_one_cycle got en=%b busy=%b want 0000/1", eng_en, busy); end
    eng_done = 4'b0100;
    tick();
    eng_done = 4'b0000;
    checks++; if (req_done !== 4'b0100) begin errors++; $display("FAIL rst_req_done got %b want 0100", req_done); end
    req = 4'b0000;
    tick();
    checks++; if (req_done !== 4'b0000 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_done_one_cycle got done=%b busy=%b want 0000/0", req_done, busy); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_oh;
    int c;
    clear_inputs();
    req = 4'b1111;
    do_reset();
    for (int g = 0; g < 5; g++) begin
      exp_oh = 4'b0001 << (g % 4);
      c = 0;
      while (eng_en == 4'b0000 && c < 8) begin
        tick();
        c++;
      end
      checks++; if (eng_en !== exp_oh) begin errors++; $display("FAIL rr_grant%0d got %b want %b", g, eng_en, exp_oh); end
      checks++; if (grant_id !== 3'(g % 4)) begin errors++; $display("FAIL rr_id%0d got %0d want %0d", g, grant_id, g % 4); end
      checks++; if (c !== ((g == 0) ? 1 : 2)) begin errors++; $display("FAIL rr_gap%0d got %0d want %0d", g, c, (g == 0) ? 1 : 2); end
      repeat (10) tick();
      eng_done = exp_oh;
      tick();
      eng_done = 4'b0000;
      checks++; if (req_done !== exp_oh) begin errors++; $display("FAIL rr_done%0d got %b want %b", g, req_done, exp_oh); end
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_bundle_mux();
    clear_inputs();
    tx_en[0] = 1'b1; tx_mode[2:0] = 3'b011; regf_addr[9:0] = 10'd50;
    tx_mode[5:3] = 3'b001; rx_en[1] = 1'b1; rx_mode[5:3] = 3'b010;
    regf_rd_en[1] = 1'b1; regf_addr[19:10] = 10'd46; bit_cnt_en[1] = 1'b1; pp_od[1] = 1'b1;
    req = 4'b0010;
    do_reset();
    checks++; if (o_tx_mode !== 3'b000 || o_regf_addr !== 10'd0 || o_tx_en !== 1'b0) begin
      errors++; $display("FAIL mux_idle got mode=%b addr=%0d en=%b want 0", o_tx_mode, o_regf_addr, o_tx_en); end
    tick();
    checks++; if (eng_en !== 4'b0010) begin errors++; $display("FAIL mux_launch got %b want 0010", eng_en); end
    checks++; if (o_tx_mode !== 3'b000 || o_regf_addr !== 10'd0) begin
      errors++; $display("FAIL mux_launch_bundle got mode=%b addr=%0d want 0", o_tx_mode, o_regf_addr); end
    tick();
    checks++; if (o_tx_mode !== 3'b001 || o_regf_addr !== 10'd46) begin
      errors++; $display("FAIL mux_active got mode=%b addr=%0d want 001/46", o_tx_mode, o_regf_addr); end
    checks++; if ({o_rx_en, o_rx_mode, o_regf_rd_en, o_bit_cnt_en, o_pp_od} !== 7'b1_010_1_1_1) begin
      errors++; $display("FAIL mux_active_rest got %b want 1010111", {o_rx_en, o_rx_mode, o_regf_rd_en, o_bit_cnt_en, o_pp_od}); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (o_tx_en !== 1'b0) begin errors++; $display("FAIL mux_no_leak%0d got %b want 0", i, o_tx_en); end
      tick();
    end
    eng_done = 4'b0010;
    tick();
    eng_done = 4'b0000;
    checks++; if (req_done !== 4'b0010) begin errors++; $display("FAIL mux_done got %b want 0010", req_done); end
    checks++; if (o_tx_mode !== 3'b000 || o_regf_addr !== 10'd0 || o_pp_od !== 1'b0) begin
      errors++; $display("FAIL mux_release got mode=%b addr=%0d pp=%b want 0", o_tx_mode, o_regf_addr, o_pp_od); end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_timeout();
    int c;
    clear_inputs();
    req = 4'b0001;
    do_reset();
    tick();
    checks++; if (eng_en !== 4'b0001) begin errors++; $display("FAIL tmo_launch got %b want 0001", eng_en); end
    c = 0;
    while (timeout !== 1'b1 && c < TMO + 5) begin
      tick();
      c++;
    end
    checks++; if (c !== TMO + 1) begin errors++; $display("FAIL tmo_latency got %0d want %0d", c, TMO + 1); end
    checks++; if (eng_abort !== 4'b0001 || req_done !== 4'b0001) begin
      errors++; $display("FAIL tmo_pulses got abort=%b done=%b want 0001/0001", eng_abort, req_done); end
    req = 4'b0000;
    tick();
    checks++; if (timeout !== 1'b0 || eng_abort !== 4'b0000 || busy !== 1'b0) begin
      errors++; $display("FAIL tmo_one_cycle got tmo=%b abort=%b busy=%b want 0", timeout, eng_abort, busy); end
    // done on the last allowed cycle must win over the timeout
    req = 4'b0001;
    do_reset();
    tick();
    repeat (TMO) tick();
    checks++; if (busy !== 1'b1 || timeout !== 1'b0) begin
      errors++; $display("FAIL tmo_edge_active got busy=%b tmo=%b want 1/0", busy, timeout); end
    eng_done = 4'b0001;
    tick();
    eng_done = 4'b0000;
    checks++; if (timeout !== 1'b0 || eng_abort !== 4'b0000 || req_done !== 4'b0001) begin
      errors++; $display("FAIL tmo_done_wins got tmo=%b abort=%b done=%b want 0/0000/0001", timeout, eng_abort, req_done); end
    req = 4'b0000;
    tick();
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL tmo_late got %b want 0", timeout); end
  endtask

  task automatic test_foreign_done();
    clear_inputs();
    req = 4'b0001;
    do_reset();
    tick();
    tick();
    req = 4'b0000;
    eng_done = 4'b1000;
    tick();
    eng_done = 4'b0000;
    checks++; if (busy !== 1'b1 || req_done !== 4'b0000 || grant_id !== 3'd0) begin
      errors++; $display("FAIL foreign_done got busy=%b done=%b id=%0d want 1/0000/0", busy, req_done, grant_id); end
    repeat (3) tick();
    checks++; if (busy !== 1'b1 || eng_en !== 4'b0000) begin
      errors++; $display("FAIL foreign_hold got busy=%b en=%b want 1/0000", busy, eng_en); end
    eng_done = 4'b0001;
    tick();
    eng_done = 4'b0000;
    checks++; if (req_done !== 4'b0001) begin errors++; $display("FAIL foreign_own_done got %b want 0001", req_done); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL foreign_idle got %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    req = 4'b0010;
    do_reset();
    tick();
    tick();
    eng_done = 4'b0010;
    tick();
    eng_done = 4'b0000;
    req = 4'b0000;
    checks++; if (req_done !== 4'b0010) begin errors++; $display("FAIL mid_first_done got %b want 0010", req_done); end
    tick();
    req = 4'b0101;
    tick();
    checks++; if (eng_en !== 4'b0100) begin errors++; $display("FAIL mid_rotate got %b want 0100", eng_en); end
    tx_en[2] = 1'b1;
    tick();
    checks++; if (o_tx_en !== 1'b1) begin errors++; $display("FAIL mid_active got %b want 1", o_tx_en); end
    rst = 1'b1;
    eng_done = 4'b0100;
    tick();
    checks++; if (busy !== 1'b0 || o_tx_en !== 1'b0 || req_done !== 4'b0000 || grant_id !== 3'd0) begin
      errors++; $display("FAIL mid_reset got busy=%b tx=%b done=%b id=%0d want 0/0/0000/0", busy, o_tx_en, req_done, grant_id); end
    rst = 1'b0;
    eng_done = 4'b0000;
    tick();
    checks++; if (eng_en !== 4'b0001 || grant_id !== 3'd0) begin
      errors++; $display("FAIL mid_ptr_reset got en=%b id=%0d want 0001/0", eng_en, grant_id); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_round_robin();
    test_bundle_mux();
    test_timeout();
    test_foreign_done();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
